// File: rtl/keypad_pattern_select.sv
// 4x4 keypad scanner with debounced pattern select and draw on key 15.
// Optional DRAW_AUTOREPEAT_EN: repeat draw while key 15 stays held.
module keypad_pattern_select #(
  parameter int DEBOUNCE_SCANS = 3,
  parameter int REPEAT_SCANS   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] keypadCol,
  output logic [3:0] keypadRow,
  output logic [3:0] pattern_idx,
  output logic       draw
);

  localparam int MAXS = (DEBOUNCE_SCANS > REPEAT_SCANS) ?
                        DEBOUNCE_SCANS : REPEAT_SCANS;
  localparam int CW = $clog2(MAXS + 1);
  localparam logic [CW-1:0] DEB = CW'(DEBOUNCE_SCANS);
  localparam logic [CW-1:0] ONE = CW'(1);

  typedef enum logic [1:0] {
    IDLE,
    CAND,
    HELD,
    REL
  } state_t;

  state_t        r_state, w_state;
  logic [1:0]    r_row;
  logic          r_found;
  logic [3:0]    r_acc;
  logic [CW-1:0] r_cnt, w_cnt, w_cnt_inc;
  logic [3:0]    r_key, w_key;
  logic [3:0]    r_pidx, w_pidx;
  logic          r_draw, w_draw;
  logic          w_fire;
  logic          w_hit;
  logic [1:0]    w_col;
  logic [3:0]    w_code;
  logic          w_eval;
  logic          w_valid;
  logic [3:0]    w_scode;

`ifdef DRAW_AUTOREPEAT_EN
  localparam logic [CW-1:0] REP = CW'(REPEAT_SCANS);
  logic [CW-1:0] r_rep, w_rep, w_rep_inc;

  assign w_rep_inc = (r_rep == '1) ? r_rep : r_rep + ONE;
`endif

  always_comb begin
    w_col = 2'd3;
    if (!keypadCol[0])      w_col = 2'd0;
    else if (!keypadCol[1]) w_col = 2'd1;
    else if (!keypadCol[2]) w_col = 2'd2;
  end

  assign w_hit  = (keypadCol != 4'hF);
  assign w_code = {r_row, w_col};
  assign w_eval = (r_row == 2'd3);

  // Rows scan in ascending order, so the first hit is the lowest code.
  assign w_valid = r_found | w_hit;
  assign w_scode = r_found ? r_acc : w_code;

  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + ONE;

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_key   = r_key;
    w_pidx  = r_pidx;
    w_draw  = 1'b0;
    w_fire  = 1'b0;
`ifdef DRAW_AUTOREPEAT_EN
    w_rep   = r_rep;
`endif
    if (w_eval) begin
      unique case (r_state)
        IDLE: begin
          if (w_valid) begin
            w_key = w_scode;
            if (DEB <= ONE) begin
              w_state = HELD;
              w_fire  = 1'b1;
              w_cnt   = '0;
            end else begin
              w_state = CAND;
              w_cnt   = ONE;
            end
          end
        end
        CAND: begin
          if (w_valid && (w_scode == r_key)) begin
            w_cnt = w_cnt_inc;
            if (w_cnt_inc >= DEB) begin
              w_state = HELD;
              w_fire  = 1'b1;
              w_cnt   = '0;
            end
          end else begin
            w_state = IDLE;
            w_cnt   = '0;
          end
        end
        HELD: begin
          if (!w_valid) begin
            if (DEB <= ONE) begin
              w_state = IDLE;
              w_cnt   = '0;
            end else begin
              w_state = REL;
              w_cnt   = ONE;
            end
          end
`ifdef DRAW_AUTOREPEAT_EN
          else if (r_key == 4'hF) begin
            if (w_rep_inc >= REP) begin
              w_draw = 1'b1;
              w_rep  = '0;
            end else begin
              w_rep = w_rep_inc;
            end
          end
`endif
        end
        REL: begin
          if (w_valid) begin
            w_state = HELD;
            w_cnt   = '0;
          end else begin
            w_cnt = w_cnt_inc;
            if (w_cnt_inc >= DEB) begin
              w_state = IDLE;
              w_cnt   = '0;
            end
          end
        end
        default: begin
          w_state = IDLE;
          w_cnt   = '0;
        end
      endcase
    end
    if (w_fire) begin
      if (w_key == 4'hF) w_draw = 1'b1;
      else               w_pidx = w_key;
    end
`ifdef DRAW_AUTOREPEAT_EN
    if (w_fire || (w_state != HELD)) w_rep = '0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_row   <= 2'd0;
      r_found <= 1'b0;
      r_acc   <= 4'd0;
      r_cnt   <= '0;
      r_key   <= 4'd0;
      r_pidx  <= 4'd0;
      r_draw  <= 1'b0;
`ifdef DRAW_AUTOREPEAT_EN
      r_rep   <= '0;
`endif
    end else begin
      r_state <= w_state;
      r_row   <= r_row + 2'd1;
      if (w_eval) begin
        r_found <= 1'b0;
      end else if (!r_found && w_hit) begin
        r_found <= 1'b1;
        r_acc   <= w_code;
      end
      r_cnt  <= w_cnt;
      r_key  <= w_key;
      r_pidx <= w_pidx;
      r_draw <= w_draw;
`ifdef DRAW_AUTOREPEAT_EN
      r_rep  <= w_rep;
`endif
    end
  end

  assign keypadRow   = ~(4'b0001 << r_row);
  assign pattern_idx = r_pidx;
  assign draw        = r_draw;

endmodule

// File: tb/tb_keypad_pattern_select.sv
// Bench for keypad_pattern_select: physical keypad model plus
// a scan-level reference model of press/release acceptance.
module tb_keypad_pattern_select;

  localparam int DEB = 3;
  localparam int REP = 8;
  localparam logic [15:0] K1  = 16'h0002;
  localparam logic [15:0] K4  = 16'h0010;
  localparam logic [15:0] K6  = 16'h0040;
  localparam logic [15:0] K9  = 16'h0200;
  localparam logic [15:0] K15 = 16'h8000;

  logic       clk;
  logic       rst;
  logic [3:0] keypadCol;
  logic [3:0] keypadRow;
  logic [3:0] pattern_idx;
  logic       draw;

  logic [15:0] keys;

  int checks;
  int errors;

  // Observations from the most recent full scan
  logic [3:0] sc_pidx;
  logic       sc_draw;
  int         sc_rowbad;
  int         sc_stray;

  // Reference model
  bit         m_active;
  int         m_cand;
  int         m_run;
  int         m_acc;
  int         m_none;
  int         m_rep;
  logic [3:0] m_pidx;
  logic       m_draw;

  keypad_pattern_select #(
    .DEBOUNCE_SCANS(DEB),
    .REPEAT_SCANS  (REP)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .keypadCol  (keypadCol),
    .keypadRow  (keypadRow),
    .pattern_idx(pattern_idx),
    .draw       (draw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pressed key at row r, col c pulls col c low while row r is driven
  always_comb begin
    keypadCol = 4'hF;
    for (int r = 0; r < 4; r++)
      if (keypadRow[r] == 1'b0)
        for (int c = 0; c < 4; c++)
          if (keys[r*4+c]) keypadCol[c] = 1'b0;
  end

  function automatic int lowest(input logic [15:0] m);
    for (int i = 0; i < 16; i++)
      if (m[i]) return i;
    return -1;
  endfunction

  task automatic model_reset;
    m_active = 0;
    m_cand   = -1;
    m_run    = 0;
    m_acc    = 0;
    m_none   = 0;
    m_rep    = 0;
    m_pidx   = 4'd0;
    m_draw   = 1'b0;
  endtask

  task automatic model_scan(input logic [15:0] m);
    int k;
    k = lowest(m);
    m_draw = 1'b0;
    if (!m_active) begin
      if (m_cand < 0) begin
        if (k >= 0) begin
          m_cand = k;
          m_run  = 1;
        end
      end else if (k == m_cand) begin
        m_run++;
      end else begin
        m_cand = -1;
        m_run  = 0;
      end
      if (m_cand >= 0 && m_run >= DEB) begin
        m_active = 1;
        m_acc    = m_cand;
        m_cand   = -1;
        m_run    = 0;
        m_none   = 0;
        m_rep    = 0;
        if (m_acc == 15) m_draw = 1'b1;
        else m_pidx = 4'(m_acc);
      end
    end else if (k >= 0) begin
      if (m_none == 0 && m_acc == 15) begin
        m_rep++;
`ifdef DRAW_AUTOREPEAT_EN
        if (m_rep == REP) begin
          m_draw = 1'b1;
          m_rep  = 0;
        end
`endif
      end
      m_none = 0;
    end else begin
      m_none++;
      m_rep = 0;
      if (m_none >= DEB) begin
        m_active = 0;
        m_none   = 0;
      end
    end
  endtask

  // One full scan: four clock edges starting with row 0 driven
  task automatic run_scan(input logic [15:0] m);
    keys      = m;
    sc_rowbad = 0;
    sc_stray  = 0;
    for (int i = 0; i < 4; i++) begin
      if (keypadRow !== ~(4'b0001 << i)) sc_rowbad++;
      @(posedge clk);
      #1;
      if (i < 3 && draw !== 1'b0) sc_stray++;
    end
    sc_pidx = pattern_idx;
    sc_draw = draw;
    model_scan(m);
  endtask

  task automatic release_all;
    for (int i = 0; i < DEB + 1; i++) run_scan(16'h0);
  endtask

  task automatic test_reset;
    rst  = 1'b1;
    keys = 16'h0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (keypadRow !== 4'b1110) begin
      errors++;
      $display("FAIL reset_row got %b want 1110", keypadRow);
    end
    checks++;
    if (pattern_idx !== 4'd0 || draw !== 1'b0) begin
      errors++;
      $display("FAIL reset_out got %0d/%b want 0/0",
               pattern_idx, draw);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    for (int s = 0; s < 2; s++) begin
      run_scan(16'h0);
      checks++;
      if (sc_rowbad !== 0) begin
        errors++;
        $display("FAIL row_seq scan %0d bad=%0d want 0",
                 s, sc_rowbad);
      end
    end
    run_scan(K6);
    run_scan(K6);
    keys = K6;
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (keypadRow !== 4'b1110) begin
      errors++;
      $display("FAIL reset_mid_row got %b want 1110", keypadRow);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    run_scan(K6);
    checks++;
    if (sc_pidx !== 4'd0 || sc_rowbad !== 0) begin
      errors++;
      $display("FAIL reset_discard got pidx=%0d rowbad=%0d want 0/0",
               sc_pidx, sc_rowbad);
    end
    run_scan(K6);
    run_scan(K6);
    checks++;
    if (sc_pidx !== 4'd6 || sc_pidx !== m_pidx) begin
      errors++;
      $display("FAIL reset_then_sel got %0d want 6", sc_pidx);
    end
    keys = K6;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if (keypadRow !== 4'b1110 || pattern_idx !== 4'd0 ||
        draw !== 1'b0) begin
      errors++;
      $display("FAIL reset_async got %b/%0d/%b want 1110/0/0",
               keypadRow, pattern_idx, draw);
    end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_bounce;
    release_all();
    run_scan(K6);
    run_scan(K6);
    run_scan(16'h0);
    run_scan(K6);
    run_scan(K6);
    checks++;
    if (sc_pidx !== 4'd0 || sc_pidx !== m_pidx) begin
      errors++;
      $display("FAIL bounce_early got %0d want 0", sc_pidx);
    end
    run_scan(K6);
    checks++;
    if (sc_pidx !== 4'd6 || sc_pidx !== m_pidx) begin
      errors++;
      $display("FAIL bounce_accept got %0d want 6", sc_pidx);
    end
  endtask

  task automatic test_select;
    release_all();
    for (int s = 0; s < DEB; s++) run_scan(K1);
    release_all();
    checks++;
    if (sc_pidx !== 4'd1) begin
      errors++;
      $display("FAIL select_pre got %0d want 1", sc_pidx);
    end
    for (int s = 1; s <= 3; s++) begin
      run_scan(K6);
      checks++;
      if (sc_pidx !== ((s == 3) ? 4'd6 : 4'd1) ||
          sc_draw !== 1'b0 || sc_stray !== 0) begin
        errors++;
        $display("FAIL select_scan%0d got %0d/%b want %0d/0",
                 s, sc_pidx, sc_draw, (s == 3) ? 6 : 1);
      end
    end
  endtask

  task automatic test_multikey;
    release_all();
    for (int s = 0; s < 3; s++) run_scan(K9 | K4);
    checks++;
    if (sc_pidx !== 4'd4 || sc_pidx !== m_pidx) begin
      errors++;
      $display("FAIL multi_low got %0d want 4", sc_pidx);
    end
    run_scan(K4);
    run_scan(K4 | K9);
    run_scan(K9);
    run_scan(K9);
    run_scan(K9);
    checks++;
    if (sc_pidx !== 4'd4 || sc_pidx !== m_pidx) begin
      errors++;
      $display("FAIL multi_hold got %0d want 4", sc_pidx);
    end
    release_all();
    for (int s = 0; s < 3; s++) run_scan(K9);
    checks++;
    if (sc_pidx !== 4'd9 || sc_pidx !== m_pidx) begin
      errors++;
      $display("FAIL multi_repress got %0d want 9", sc_pidx);
    end
  endtask

  task automatic test_draw;
    logic [31:0] seen;
    logic [31:0] want;
    logic [3:0]  p0;
`ifdef DRAW_AUTOREPEAT_EN
    want = (32'd1 << 3) | (32'd1 << 11) | (32'd1 << 19);
`else
    want = (32'd1 << 3);
`endif
    release_all();
    p0   = sc_pidx;
    seen = 32'd0;
    for (int s = 1; s <= 20; s++) begin
      run_scan(K15);
      if (sc_draw === 1'b1) seen[s] = 1'b1;
      checks++;
      if (sc_draw !== m_draw || sc_stray !== 0) begin
        errors++;
        $display("FAIL draw_scan%0d got %b stray=%0d want %b",
                 s, sc_draw, sc_stray, m_draw);
      end
    end
    checks++;
    if (seen !== want) begin
      errors++;
      $display("FAIL draw_pulses got %h want %h", seen, want);
    end
    checks++;
    if (sc_pidx !== p0) begin
      errors++;
      $display("FAIL draw_pidx got %0d want %0d", sc_pidx, p0);
    end
  endtask

  task automatic test_release_glitch;
    int pulses;
    release_all();
    pulses = 0;
    for (int s = 0; s < 3; s++) begin
      run_scan(K15);
      if (sc_draw === 1'b1) pulses++;
    end
    run_scan(16'h0);
    if (sc_draw === 1'b1) pulses++;
    for (int s = 0; s < 3; s++) begin
      run_scan(K15);
      if (sc_draw === 1'b1) pulses++;
      pulses += sc_stray;
    end
    checks++;
    if (pulses !== 1) begin
      errors++;
      $display("FAIL glitch_pulses got %0d want 1", pulses);
    end
    release_all();
  endtask

  task automatic test_random;
    logic [15:0] m;
    int          len;
    int          kind;
    int          n;
    n = 0;
    while (n < 250) begin
      kind = $urandom_range(0, 9);
      if (kind < 3) begin
        m = 16'h0;
      end else begin
        m = 16'h0;
        m[$urandom_range(0, 15)] = 1'b1;
        if (kind > 7) m[$urandom_range(0, 15)] = 1'b1;
      end
      len = $urandom_range(1, 5);
      for (int s = 0; s < len; s++) begin
        run_scan(m);
        n++;
        checks++;
        if (sc_pidx !== m_pidx || sc_draw !== m_draw ||
            sc_rowbad !== 0 || sc_stray !== 0) begin
          errors++;
          $display("FAIL rand_scan%0d keys=%h got %0d/%b r%0d s%0d want %0d/%b",
                   n, m, sc_pidx, sc_draw, sc_rowbad, sc_stray,
                   m_pidx, m_draw);
        end
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    keys   = 16'h0;
    rst    = 1'b1;
    model_reset();
    test_reset();
    test_bounce();
    test_select();
    test_multikey();
    test_draw();
    test_release_glitch();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
